// File: rtl/quad_step_encoder_pkg.sv
// Shared constants for the quadrature step encoder: direction codes,
// per-phase (a,b) patterns and the sequencer state encoding.
package quad_pkg;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam logic [1:0] AB_REST = 2'b11;

  // CW: A falls first, so B is low when A rises again
  localparam logic [1:0] CW_PH0 = 2'b01;
  localparam logic [1:0] CW_PH1 = 2'b00;
  localparam logic [1:0] CW_PH2 = 2'b10;
  localparam logic [1:0] CW_PH3 = 2'b11;

  localparam logic [1:0] CCW_PH0 = 2'b10;
  localparam logic [1:0] CCW_PH1 = 2'b00;
  localparam logic [1:0] CCW_PH2 = 2'b01;
  localparam logic [1:0] CCW_PH3 = 2'b11;

  localparam logic [1:0] LAST_PHASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } qstate_e;

  function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] ph);
    logic [1:0] ab;
    ab = AB_REST;
    if (dir == DIR_CW) begin
      case (ph)
        2'd0:    ab = CW_PH0;
        2'd1:    ab = CW_PH1;
        2'd2:    ab = CW_PH2;
        default: ab = CW_PH3;
      endcase
    end else begin
      case (ph)
        2'd0:    ab = CCW_PH0;
        2'd1:    ab = CCW_PH1;
        2'd2:    ab = CCW_PH2;
        default: ab = CCW_PH3;
      endcase
    end
    return ab;
  endfunction

endpackage

// File: rtl/quad_step_encoder_phase_timer.sv
// Free-running prescaler: counts 0..PERIOD-1, pulses tick on the last count,
// and restarts from 0 on tick or on a synchronous clear.
module phase_timer #(
  parameter int unsigned PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_step_encoder.sv
// Quadrature step transmitter: turns a (direction, detent count)
// command into full four-phase A/B cycles that always end at rest (11).
//
// state | meaning
// IDLE  | a=b=1, waiting for a command
// RUN   | stepping through phases 0..3 of the current detent
// FIN   | single-cycle completion, done pulses
module quad_step_encoder
  import quad_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 1000,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  qstate_e          state, state_n;
  logic             dir_q, dir_n;
  logic [1:0]       phase_q, phase_n;
  logic [CNT_W-1:0] steps_q, steps_n;
  logic             abort_q, abort_n;
  logic [1:0]       ab_q, ab_n;
  logic             timer_clr;
  logic             tick;
  logic [CNT_W-1:0] steps_dec;
  logic [1:0]       phase_inc;
  logic             abort_seen;

  phase_timer #(
    .PERIOD (PHASE_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  assign steps_dec  = steps_q - 1'b1;
  assign phase_inc  = phase_q + 1'b1;
  // an abort arriving on the very tick that ends a detent still counts
  assign abort_seen = abort_q | abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir_q   <= DIR_CCW;
      phase_q <= 2'd0;
      steps_q <= '0;
      abort_q <= 1'b0;
      ab_q    <= AB_REST;
    end else begin
      state   <= state_n;
      dir_q   <= dir_n;
      phase_q <= phase_n;
      steps_q <= steps_n;
      abort_q <= abort_n;
      ab_q    <= ab_n;
    end
  end

  always_comb begin
    state_n   = state;
    dir_n     = dir_q;
    phase_n   = phase_q;
    steps_n   = steps_q;
    abort_n   = abort_q;
    ab_n      = ab_q;
    timer_clr = 1'b0;
    case (state)
      IDLE: begin
        abort_n = 1'b0;
        ab_n    = AB_REST;
        if (cmd_valid) begin
          dir_n     = cmd_dir;
          steps_n   = cmd_steps;
          phase_n   = 2'd0;
          timer_clr = 1'b1;
          if (cmd_steps != '0) begin
            state_n = RUN;
            ab_n    = phase_ab(cmd_dir, 2'd0);
          end else begin
            state_n = FIN;
          end
        end
      end
      RUN: begin
        abort_n = abort_seen;
        if (tick) begin
          if (phase_q == LAST_PHASE) begin
            steps_n = steps_dec;
            if ((steps_dec == '0) || abort_seen) begin
              state_n = FIN;
              ab_n    = AB_REST;
            end else begin
              phase_n = 2'd0;
              ab_n    = phase_ab(dir_q, 2'd0);
            end
          end else begin
            phase_n = phase_inc;
            ab_n    = phase_ab(dir_q, phase_inc);
          end
        end
      end
      FIN: begin
        abort_n = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        ab_n    = AB_REST;
      end
    endcase
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == RUN);
  assign done       = (state == FIN);
  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign steps_left = steps_q;

endmodule
